// File: rtl/lenet_pkg.sv
// Shared LeNet-1 accelerator definitions: FP16 field layout, constants and
// default feature-map geometry used by the conv/pool stages.
package lenet_pkg;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_INF  = 16'h7C00;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam int          EXP_MSB   = 14;
    localparam int          EXP_LSB   = 10;

    localparam int IMG_W_DEF = 28;
    localparam int K_DEF     = 5;
    localparam int OUT_W_DEF = IMG_W_DEF - K_DEF + 1;
    localparam int P_W_DEF   = OUT_W_DEF / 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/FP16_Add.sv
// Combinational IEEE binary16 adder, round-to-nearest-even, with subnormal,
// infinity and NaN handling.
module FP16_Add
    import lenet_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic [15:0] xa, xb;
    logic        sx, sy, sub, sticky;
    logic [4:0]  ex, ey, d, lz, sh;
    logic [13:0] ax, ay, ay_sh, norm;
    logic [14:0] sum;
    logic [5:0]  en, ef;
    logic [11:0] rnd;
    logic [9:0]  frac;

    always_comb begin
        // xa always carries the larger magnitude, so subtraction never goes negative
        xa = (a[14:0] >= b[14:0]) ? a : b;
        xb = (a[14:0] >= b[14:0]) ? b : a;
        sx = xa[15];
        sy = xb[15];
        sub = sx ^ sy;
        ex = (xa[14:10] == 5'd0) ? 5'd1 : xa[14:10];
        ey = (xb[14:10] == 5'd0) ? 5'd1 : xb[14:10];
        ax = {(xa[14:10] != 5'd0), xa[9:0], 3'b000};
        ay = {(xb[14:10] != 5'd0), xb[9:0], 3'b000};
        d  = ex - ey;
        if (d >= 5'd14) begin
            ay_sh  = '0;
            sticky = |ay;
        end else begin
            ay_sh  = ay >> d;
            sticky = |(ay & ~(14'h3FFF << d));
        end
        ay_sh[0] = ay_sh[0] | sticky;
        sum = sub ? ({1'b0, ax} - {1'b0, ay_sh}) : ({1'b0, ax} + {1'b0, ay_sh});

        lz = 5'd14;
        for (int i = 0; i <= 13; i++) begin
            if (sum[i]) lz = 5'(13 - i);
        end

        sh = '0;
        if (sum[14]) begin
            norm    = sum[14:1];
            norm[0] = sum[1] | sum[0];
            en      = {1'b0, ex} + 6'd1;
        end else begin
            sh   = (lz < ex) ? lz : (ex - 5'd1);
            norm = sum[13:0] << sh;
            en   = {1'b0, ex} - {1'b0, sh};
        end

        rnd = {1'b0, norm[13:3]} + {11'b0, (norm[2] & (norm[1] | norm[0] | norm[3]))};
        if (rnd[11]) begin
            ef = en + 6'd1;
        end else if (rnd[10]) begin
            ef = en;
        end else begin
            ef = 6'd0;
        end
        frac = rnd[11] ? 10'd0 : rnd[9:0];

        if (xa[14:10] == 5'd31) begin
            if ((xa[9:0] != 10'd0) || (sub && (xb[14:0] == FP16_INF[14:0])))
                y = FP16_QNAN;
            else
                y = xa;
        end else if (sum == 15'd0) begin
            y = {sx & sy, 15'b0};
        end else if (ef >= 6'd31) begin
            y = {sx, FP16_INF[14:0]};
        end else begin
            y = {sx, ef[4:0], frac};
        end
    end

endmodule

// File: rtl/fp16_div4.sv
// Divide an FP16 value by four by exponent adjustment; values that would
// leave the normal range flush to signed zero, inf/NaN pass through.
module fp16_div4
    import lenet_pkg::*;
(
    input  logic [15:0] a,
    output logic [15:0] y
);
    logic [4:0] e;

    always_comb begin
        e = a[EXP_MSB:EXP_LSB];
        if (e == 5'd31) begin
            y = a;
        end else if (e <= 5'd2) begin
            y = {a[15], 15'b0};
        end else begin
            y = {a[15], e - 5'd2, a[9:0]};
        end
    end

endmodule

// File: rtl/avg_pool2_fp16.sv
// Streaming 2x2 average pooling of the conv2d raster: drops the incomplete
// border, sums horizontal pairs, then vertical pairs via a line buffer.
module avg_pool2_fp16
    import lenet_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int K     = K_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic [15:0] in_data,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_last
);
    localparam int OUT_W = IMG_W - K + 1;
    localparam int P_W   = OUT_W / 2;
    localparam int CW    = clog2(IMG_W);
    localparam logic [CW-1:0] BORDER   = CW'(K - 1);
    localparam logic [CW-1:0] LAST_POS = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LAST_V   = CW'(OUT_W - 1);

    logic [CW-1:0] col, row, cur_col, cur_row, vc, vr;
    logic          keep;
    logic [15:0]   hold, h_sum, v_sum, q;
    logic          s1_valid, s1_odd_row, s1_last;
    logic [15:0]   s1_h;
    logic [CW-2:0] s1_pc;
    logic [15:0]   lb [P_W];

    // in_sof overrides whatever position the counters currently hold
    always_comb begin
        cur_col = (in_valid && in_sof) ? '0 : col;
        cur_row = (in_valid && in_sof) ? '0 : row;
        keep    = (cur_col >= BORDER) && (cur_row >= BORDER);
        vc      = cur_col - BORDER;
        vr      = cur_row - BORDER;
    end

    FP16_Add u_add_h (.a(hold), .b(in_data), .y(h_sum));
    FP16_Add u_add_v (.a(lb[s1_pc]), .b(s1_h), .y(v_sum));
    fp16_div4 u_div4 (.a(v_sum), .y(q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (cur_col == LAST_POS) begin
                col <= '0;
                row <= (cur_row == LAST_POS) ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold       <= FP16_ZERO;
            s1_valid   <= 1'b0;
            s1_h       <= FP16_ZERO;
            s1_pc      <= '0;
            s1_odd_row <= 1'b0;
            s1_last    <= 1'b0;
        end else begin
            s1_valid <= in_valid && keep && vc[0];
            if (in_valid && keep) begin
                if (!vc[0]) begin
                    hold <= in_data;
                end else begin
                    s1_h       <= h_sum;
                    s1_pc      <= vc[CW-1:1];
                    s1_odd_row <= vr[0];
                    s1_last    <= (vr == LAST_V) && (vc == LAST_V);
                end
            end
        end
    end

    // Line buffer is not reset: each entry is written on an even row before use
    always_ff @(posedge clk) begin
        if (s1_valid && !s1_odd_row) lb[s1_pc] <= s1_h;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= FP16_ZERO;
        end else begin
            out_valid <= s1_valid && s1_odd_row;
            out_last  <= s1_valid && s1_odd_row && s1_last;
            if (s1_valid && s1_odd_row) out_data <= q;
        end
    end

endmodule

// File: tb/tb_avg_pool2_fp16.sv
// Directed bench for avg_pool2_fp16: full frames of known pixel patterns,
// gaps, reset and resync scenarios, each checked against hand-computed values.
module tb_avg_pool2_fp16;

    localparam int  IMG_W = 28;
    localparam int  K     = 5;
    localparam int  NPIX  = IMG_W * IMG_W;
    localparam int  NOUT  = 144;
    localparam time T_CLK = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] got_q[$];
    logic        got_last_q[$];
    time         got_t_q[$];
    logic [15:0] exp_q[$];
    time         t_55;

    avg_pool2_fp16 #(.IMG_W(IMG_W), .K(K)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last)
    );

    always #(T_CLK / 2) clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            got_q.push_back(out_data);
            got_last_q.push_back(out_last);
            got_t_q.push_back($time);
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    // Pixel patterns: 0 = all 1.0; 1 = block 1,2,3,4 at raster (4..5,4..5);
    // 2 = tiny-normal block at (4,4..5) plus an infinity at (4,6).
    function automatic logic [15:0] pix(input int mode, input int r, input int c);
        if (mode == 0) return 16'h3C00;
        if (mode == 1) begin
            if (r == 4 && c == 4) return 16'h3C00;
            if (r == 4 && c == 5) return 16'h4000;
            if (r == 5 && c == 4) return 16'h4200;
            if (r == 5 && c == 5) return 16'h4400;
            return 16'h0000;
        end
        if (r == 4 && (c == 4 || c == 5)) return 16'h0400;
        if (r == 4 && c == 6) return 16'h7C00;
        return 16'h0000;
    endfunction

    // Hand-computed pooled result k of a frame with the given pattern
    function automatic logic [15:0] expv(input int mode, input int k);
        if (mode == 0) return 16'h3C00;
        if (mode == 1) return (k == 0) ? 16'h4100 : 16'h0000;
        return (k == 1) ? 16'h7C00 : 16'h0000;
    endfunction

    function automatic int data_errors(input int ma, input int mb, output int fi,
                                       output logic [15:0] fg, output logic [15:0] fe);
        int n;
        logic [15:0] e;
        n = 0; fi = -1; fg = '0; fe = '0;
        exp_q.delete();
        for (int k = 0; k < got_q.size(); k++) begin
            e = expv((k < NOUT) ? ma : mb, k % NOUT);
            exp_q.push_back(e);
            if (got_q[k] !== e) begin
                if (n == 0) begin fi = k; fg = got_q[k]; fe = e; end
                n++;
            end
        end
        return n;
    endfunction

    function automatic int last_errors();
        int n;
        n = 0;
        for (int k = 0; k < got_last_q.size(); k++)
            if (got_last_q[k] !== (k % NOUT == NOUT - 1)) n++;
        return n;
    endfunction

    task automatic clear_capture();
        got_q.delete();
        got_last_q.delete();
        got_t_q.delete();
    endtask

    task automatic send_frame(input int mode, input bit sof_first, input bit gaps, input int n);
        for (int i = 0; i < n; i++) begin
            int r, c;
            r = (i / IMG_W) % IMG_W;
            c = i % IMG_W;
            in_valid = 1'b1;
            in_data  = pix(mode, r, c);
            in_sof   = sof_first && (i == 0);
            if (r == 5 && c == 5) t_55 = $time;
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
            in_data  = 16'h0000;
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        tests_run++;
        if (out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_last: got %b want 0", out_last); end
        tests_run++;
        if (out_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_data: got %h want 0000", out_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ones_frame();
        int bad, fi;
        logic [15:0] fg, fe;
        time lat;
        clear_capture();
        send_frame(0, 1'b1, 1'b0, NPIX);
        repeat (4) @(negedge clk);
        tests_run++;
        if (got_q.size() !== NOUT) begin tests_failed++; $display("FAIL ones_count: got %0d want %0d", got_q.size(), NOUT); end
        bad = data_errors(0, 0, fi, fg, fe);
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL ones_data: %0d wrong, first idx %0d got %h want %h", bad, fi, fg, fe); end
        tests_run++;
        if (last_errors() !== 0) begin tests_failed++; $display("FAIL ones_last: %0d misplaced out_last flags, want 0", last_errors()); end
        lat = (got_t_q.size() > 0) ? (got_t_q[0] - t_55) : 0;
        tests_run++;
        if (lat !== 2 * T_CLK) begin tests_failed++; $display("FAIL ones_latency: got %0t want %0t", lat, 2 * T_CLK); end
    endtask

    task automatic test_block_values();
        int bad, fi;
        logic [15:0] fg, fe;
        clear_capture();
        send_frame(1, 1'b1, 1'b0, NPIX);
        repeat (4) @(negedge clk);
        tests_run++;
        if (got_q.size() !== NOUT) begin tests_failed++; $display("FAIL block_count: got %0d want %0d", got_q.size(), NOUT); end
        bad = data_errors(1, 1, fi, fg, fe);
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL block_data: %0d wrong, first idx %0d got %h want %h", bad, fi, fg, fe); end
    endtask

    task automatic test_flush_and_inf();
        int bad, fi;
        logic [15:0] fg, fe;
        clear_capture();
        send_frame(2, 1'b1, 1'b0, NPIX);
        repeat (4) @(negedge clk);
        tests_run++;
        if (got_q.size() !== NOUT) begin tests_failed++; $display("FAIL special_count: got %0d want %0d", got_q.size(), NOUT); end
        bad = data_errors(2, 2, fi, fg, fe);
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL special_data: %0d wrong, first idx %0d got %h want %h", bad, fi, fg, fe); end
    endtask

    task automatic test_gaps();
        int bad, fi;
        logic [15:0] fg, fe;
        clear_capture();
        send_frame(0, 1'b1, 1'b1, NPIX);
        repeat (4) @(negedge clk);
        tests_run++;
        if (got_q.size() !== NOUT) begin tests_failed++; $display("FAIL gaps_count: got %0d want %0d", got_q.size(), NOUT); end
        bad = data_errors(0, 0, fi, fg, fe);
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL gaps_data: %0d wrong, first idx %0d got %h want %h", bad, fi, fg, fe); end
        tests_run++;
        if (last_errors() !== 0) begin tests_failed++; $display("FAIL gaps_last: %0d misplaced out_last flags, want 0", last_errors()); end
    endtask

    task automatic test_back_to_back();
        int bad, fi;
        logic [15:0] fg, fe;
        clear_capture();
        send_frame(1, 1'b1, 1'b0, NPIX);
        send_frame(0, 1'b1, 1'b0, NPIX);
        repeat (4) @(negedge clk);
        tests_run++;
        if (got_q.size() !== 2 * NOUT) begin tests_failed++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), 2 * NOUT); end
        bad = data_errors(1, 0, fi, fg, fe);
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL b2b_data: %0d wrong, first idx %0d got %h want %h", bad, fi, fg, fe); end
        tests_run++;
        if (last_errors() !== 0) begin tests_failed++; $display("FAIL b2b_last: %0d misplaced out_last flags, want 0", last_errors()); end
    endtask

    task automatic test_reset_midframe(input bit sof_after);
        int bad, fi;
        logic [15:0] fg, fe;
        send_frame(0, 1'b1, 1'b0, 15 * IMG_W + 10 + 1);
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
            tests_failed++; $display("FAIL midrst_clear: got valid %b data %h want 0 0000", out_valid, out_data);
        end
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_hold: got valid %b want 0", out_valid); end
        rst = 1'b0;
        @(negedge clk);
        clear_capture();
        send_frame(1, sof_after, 1'b0, NPIX);
        repeat (4) @(negedge clk);
        tests_run++;
        if (got_q.size() !== NOUT) begin tests_failed++; $display("FAIL midrst_count(sof=%0d): got %0d want %0d", sof_after, got_q.size(), NOUT); end
        bad = data_errors(1, 1, fi, fg, fe);
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL midrst_data(sof=%0d): %0d wrong, first idx %0d got %h want %h", sof_after, bad, fi, fg, fe); end
        tests_run++;
        if (last_errors() !== 0) begin tests_failed++; $display("FAIL midrst_last(sof=%0d): %0d misplaced flags, want 0", sof_after, last_errors()); end
    endtask

    task automatic test_sof_midframe();
        int bad, fi;
        logic [15:0] fg, fe;
        send_frame(0, 1'b1, 1'b0, 20 * IMG_W + 3);
        repeat (4) @(negedge clk);
        clear_capture();
        send_frame(1, 1'b1, 1'b0, NPIX);
        repeat (4) @(negedge clk);
        tests_run++;
        if (got_q.size() !== NOUT) begin tests_failed++; $display("FAIL sofmid_count: got %0d want %0d", got_q.size(), NOUT); end
        bad = data_errors(1, 1, fi, fg, fe);
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL sofmid_data: %0d wrong, first idx %0d got %h want %h", bad, fi, fg, fe); end
        tests_run++;
        if (last_errors() !== 0) begin tests_failed++; $display("FAIL sofmid_last: %0d misplaced out_last flags, want 0", last_errors()); end
    endtask

    initial begin
        test_reset();
        test_ones_frame();
        test_block_values();
        test_flush_and_inf();
        test_gaps();
        test_back_to_back();
        test_reset_midframe(1'b1);
        test_reset_midframe(1'b0);
        test_sof_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
